// File: rtl/navigate_if.sv
// Command/sensor bundle between the maze solver, PID/IR sensing and the
// navigate motion sequencer.
interface navigate_if;
    logic        strt_hdng;
    logic        strt_mv;
    logic        stp_lft;
    logic        stp_rght;
    logic        hdng_rdy;
    logic        at_hdng;
    logic        lft_opn;
    logic        rght_opn;
    logic        frwrd_opn;
    logic        mv_cmplt;
    logic        moving;
    logic        en_fusion;
    logic [10:0] frwrd_spd;

    modport master (
        output strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng,
               lft_opn, rght_opn, frwrd_opn,
        input  mv_cmplt, moving, en_fusion, frwrd_spd
    );

    modport slave (
        input  strt_hdng, strt_mv, stp_lft, stp_rght, hdng_rdy, at_hdng,
               lft_opn, rght_opn, frwrd_opn,
        output mv_cmplt, moving, en_fusion, frwrd_spd
    );
endinterface

// File: rtl/navigate.sv
// Motion sequencer: runs heading changes to completion and ramps forward
// speed up and down around side-opening and obstacle stop conditions.
module navigate #(
    parameter logic [10:0] FRWRD_INC     = 11'h018,
    parameter logic [10:0] MAX_FRWRD     = 11'h2A0,
    parameter logic [10:0] FUSION_THRESH = 11'h150
) (
    input  logic      clk,
    input  logic      rst_n,
    navigate_if.slave nav
);

    typedef enum logic [1:0] {IDLE, HDNG, RAMP_UP, RAMP_DOWN} state_e;

    state_e      state_q, state_d;
    logic [10:0] spd_q, spd_d;
    logic        stp_lft_q, stp_lft_d;
    logic        stp_rght_q, stp_rght_d;
    logic        lft_hist_q, lft_hist_d;
    logic        rght_hist_q, rght_hist_d;
    logic        emerg_q, emerg_d;
    logic        cmplt;

    logic [11:0] spd_inc;
    logic [10:0] dec;
    logic        side_stop;

    // One spare bit so the saturation compare sees the true sum.
    assign spd_inc   = {1'b0, spd_q} + {1'b0, FRWRD_INC};
    assign dec       = emerg_q ? (FRWRD_INC << 3) : (FRWRD_INC << 1);
    assign side_stop = (stp_lft_q  & nav.lft_opn  & ~lft_hist_q) |
                       (stp_rght_q & nav.rght_opn & ~rght_hist_q);

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d     = state_q;
        spd_d       = spd_q;
        stp_lft_d   = stp_lft_q;
        stp_rght_d  = stp_rght_q;
        lft_hist_d  = lft_hist_q;
        rght_hist_d = rght_hist_q;
        emerg_d     = emerg_q;
        cmplt       = 1'b0;

        unique case (state_q)
            IDLE: begin
                spd_d = '0;
                if (nav.strt_hdng) begin
                    state_d = HDNG;
                end else if (nav.strt_mv) begin
                    state_d     = RAMP_UP;
                    stp_lft_d   = nav.stp_lft;
                    stp_rght_d  = nav.stp_rght;
                    // Openings already present at the start must not trigger a stop.
                    lft_hist_d  = nav.lft_opn;
                    rght_hist_d = nav.rght_opn;
                end
            end
            HDNG: begin
                spd_d = '0;
                if (nav.at_hdng) begin
                    cmplt   = 1'b1;
                    state_d = IDLE;
                end
            end
            RAMP_UP: begin
                if (nav.hdng_rdy)
                    spd_d = (spd_inc > {1'b0, MAX_FRWRD}) ? MAX_FRWRD : spd_inc[10:0];
                lft_hist_d  = nav.lft_opn;
                rght_hist_d = nav.rght_opn;
                if (!nav.frwrd_opn) begin
                    state_d = RAMP_DOWN;
                    emerg_d = 1'b1;
                end else if (side_stop) begin
                    state_d = RAMP_DOWN;
                    emerg_d = 1'b0;
                end
            end
            RAMP_DOWN: begin
                lft_hist_d  = nav.lft_opn;
                rght_hist_d = nav.rght_opn;
                if (!nav.frwrd_opn)
                    emerg_d = 1'b1;
                if (spd_q == '0) begin
                    cmplt      = 1'b1;
                    state_d    = IDLE;
                    stp_lft_d  = 1'b0;
                    stp_rght_d = 1'b0;
                end else if (nav.hdng_rdy) begin
                    spd_d = (spd_q <= dec) ? '0 : spd_q - dec;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops
    // update together from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            spd_q       <= '0;
            stp_lft_q   <= 1'b0;
            stp_rght_q  <= 1'b0;
            lft_hist_q  <= 1'b0;
            rght_hist_q <= 1'b0;
            emerg_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            spd_q       <= spd_d;
            stp_lft_q   <= stp_lft_d;
            stp_rght_q  <= stp_rght_d;
            lft_hist_q  <= lft_hist_d;
            rght_hist_q <= rght_hist_d;
            emerg_q     <= emerg_d;
        end
    end

    assign nav.mv_cmplt  = cmplt;
    assign nav.moving    = (state_q != IDLE);
    assign nav.en_fusion = ((state_q == RAMP_UP) || (state_q == RAMP_DOWN)) &&
                           (spd_q > FUSION_THRESH);
    assign nav.frwrd_spd = spd_q;

endmodule

// File: tb/tb_navigate.sv
// Self-checking bench for navigate: directed table and sequences plus
// randomized traffic checked against a behavioural motion model.
module tb_navigate;

    localparam int INC  = 24;
    localparam int MAXS = 672;
    localparam int THR  = 336;

    logic clk;
    logic rst_n;

    navigate_if nav_if ();

    navigate dut (
        .clk  (clk),
        .rst_n(rst_n),
        .nav  (nav_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_errors;

    // Behavioural model: what the robot is doing and how fast.
    int m_activity;  // 0 parked, 1 turning, 2 accelerating, 3 braking
    int m_spd;
    int m_brake;     // speed removed per gyro update while braking
    bit m_sl, m_sr, m_lh, m_rh;

    logic        obs_cmplt, obs_moving, obs_fusion;
    logic [10:0] obs_spd;

    typedef struct {
        logic        rst_n;
        logic        strt_hdng;
        logic        at_hdng;
        logic        exp_moving;
        logic        exp_cmplt;
        logic [10:0] exp_spd;
    } turn_vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_activity = 0;
        m_spd      = 0;
        m_brake    = 2 * INC;
        m_sl = 0; m_sr = 0; m_lh = 0; m_rh = 0;
    endtask

    task automatic model_step();
        bit lrise, rrise;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lrise = nav_if.lft_opn & ~m_lh;
        rrise = nav_if.rght_opn & ~m_rh;
        case (m_activity)
            0: begin
                m_spd = 0;
                if (nav_if.strt_hdng) m_activity = 1;
                else if (nav_if.strt_mv) begin
                    m_activity = 2;
                    m_sl = nav_if.stp_lft;  m_sr = nav_if.stp_rght;
                    m_lh = nav_if.lft_opn;  m_rh = nav_if.rght_opn;
                end
            end
            1: if (nav_if.at_hdng) m_activity = 0;
            2: begin
                if (nav_if.hdng_rdy) m_spd = (m_spd + INC > MAXS) ? MAXS : m_spd + INC;
                if (!nav_if.frwrd_opn) begin
                    m_activity = 3; m_brake = 8 * INC;
                end else if ((m_sl && lrise) || (m_sr && rrise)) begin
                    m_activity = 3; m_brake = 2 * INC;
                end
                m_lh = nav_if.lft_opn; m_rh = nav_if.rght_opn;
            end
            default: begin
                if (m_spd == 0) begin
                    m_activity = 0; m_sl = 0; m_sr = 0;
                end else if (nav_if.hdng_rdy) begin
                    m_spd = (m_spd <= m_brake) ? 0 : m_spd - m_brake;
                end
                if (!nav_if.frwrd_opn) m_brake = 8 * INC;
                m_lh = nav_if.lft_opn; m_rh = nav_if.rght_opn;
            end
        endcase
    endtask

    // One clock: sample at the falling edge, compare with the model, advance.
    task automatic tick();
        logic e_cmplt, e_moving, e_fusion;
        @(negedge clk);
        obs_cmplt  = nav_if.mv_cmplt;
        obs_moving = nav_if.moving;
        obs_fusion = nav_if.en_fusion;
        obs_spd    = nav_if.frwrd_spd;
        e_moving = (m_activity != 0);
        e_fusion = (m_activity >= 2) && (m_spd > THR);
        e_cmplt  = (m_activity == 1 && nav_if.at_hdng) || (m_activity == 3 && m_spd == 0);
        check("model_spd",    32'(obs_spd),    32'(m_spd));
        check("model_moving", 32'(obs_moving), 32'(e_moving));
        check("model_fusion", 32'(obs_fusion), 32'(e_fusion));
        check("model_cmplt",  32'(obs_cmplt),  32'(e_cmplt));
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        nav_if.strt_hdng = 0; nav_if.strt_mv = 0; nav_if.stp_lft = 0; nav_if.stp_rght = 0;
        nav_if.hdng_rdy = 0; nav_if.at_hdng = 0; nav_if.lft_opn = 0; nav_if.rght_opn = 0;
        nav_if.frwrd_opn = 1;
    endtask

    task automatic start_move(input bit sl, input bit sr);
        nav_if.strt_mv = 1; nav_if.stp_lft = sl; nav_if.stp_rght = sr;
        tick();
        nav_if.strt_mv = 0; nav_if.stp_lft = 0; nav_if.stp_rght = 0;
    endtask

    initial begin
        turn_vec_t   tv[10];
        logic [10:0] emg_exp[5];
        int          cmplt_cnt, cmplt_at;

        n_checks = 0;
        n_errors = 0;
        tv[0] = '{0, 0, 0, 0, 0, 11'h000};
        tv[1] = '{1, 0, 0, 0, 0, 11'h000};
        tv[2] = '{1, 1, 0, 0, 0, 11'h000};
        tv[3] = '{1, 0, 0, 1, 0, 11'h000};
        tv[4] = '{1, 0, 0, 1, 0, 11'h000};
        tv[5] = '{1, 0, 0, 1, 0, 11'h000};
        tv[6] = '{1, 0, 0, 1, 0, 11'h000};
        tv[7] = '{1, 0, 1, 1, 1, 11'h000};
        tv[8] = '{1, 0, 0, 0, 0, 11'h000};
        tv[9] = '{1, 0, 1, 0, 0, 11'h000};
        emg_exp[0] = 11'h2A0; emg_exp[1] = 11'h1E0; emg_exp[2] = 11'h120;
        emg_exp[3] = 11'h060; emg_exp[4] = 11'h000;

        idle_inputs();
        model_reset();
        rst_n = 0;
        @(posedge clk);
        #1;

        // Reset, then a turn completing five cycles after it starts.
        for (int i = 0; i < 10; i++) begin
            rst_n = tv[i].rst_n;
            nav_if.strt_hdng = tv[i].strt_hdng;
            nav_if.at_hdng   = tv[i].at_hdng;
            tick();
            check($sformatf("turn_moving[%0d]", i), 32'(obs_moving), 32'(tv[i].exp_moving));
            check($sformatf("turn_cmplt[%0d]", i),  32'(obs_cmplt),  32'(tv[i].exp_cmplt));
            check($sformatf("turn_spd[%0d]", i),    32'(obs_spd),    32'(tv[i].exp_spd));
            check($sformatf("turn_fusion[%0d]", i), 32'(obs_fusion), 32'd0);
        end
        idle_inputs();

        // Ramp to saturation with a left opening already present at start.
        nav_if.hdng_rdy = 1;
        nav_if.lft_opn  = 1;
        start_move(1, 0);
        for (int k = 0; k < 32; k++) begin
            int exp_spd;
            exp_spd = (k * INC > MAXS) ? MAXS : k * INC;
            tick();
            check("ramp_spd", 32'(obs_spd), 32'(exp_spd));
            if (exp_spd == 'h150) check("fusion_at_150", 32'(obs_fusion), 32'd0);
            if (exp_spd == 'h168) check("fusion_at_168", 32'(obs_fusion), 32'd1);
        end
        check("ramp_still_moving", 32'(obs_moving), 32'd1);

        // Left opening closes and reopens: gentle stop.
        nav_if.lft_opn = 0; tick();
        nav_if.lft_opn = 1; tick();
        cmplt_cnt = 0; cmplt_at = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (obs_cmplt) begin
                cmplt_cnt++;
                cmplt_at = i;
            end
        end
        check("lstop_cmplt_count", 32'(cmplt_cnt), 32'd1);
        check("lstop_cmplt_cycle", 32'(cmplt_at), 32'd15);
        check("lstop_parked", 32'(obs_moving), 32'd0);
        idle_inputs();

        // Right-stop move ignores a left opening, stops on a right one.
        nav_if.hdng_rdy = 1;
        start_move(0, 1);
        tick(); tick(); tick();
        nav_if.lft_opn = 1; tick();
        tick(); tick();
        check("sel_still_ramping", 32'(obs_spd), 32'h078);
        nav_if.rght_opn = 1; tick();
        cmplt_cnt = 0;
        for (int i = 0; i < 40 && cmplt_cnt == 0; i++) begin
            tick();
            if (obs_cmplt) cmplt_cnt++;
        end
        check("sel_right_stop", 32'(cmplt_cnt), 32'd1);
        idle_inputs();

        // Emergency brake from full speed.
        nav_if.hdng_rdy = 1;
        start_move(0, 0);
        for (int k = 0; k < 30; k++) tick();
        nav_if.frwrd_opn = 0; tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("emg_spd[%0d]", i), 32'(obs_spd), 32'(emg_exp[i]));
            check($sformatf("emg_cmplt[%0d]", i), 32'(obs_cmplt), 32'(i == 4));
        end
        idle_inputs();
        tick();

        // Reset in the middle of a move.
        nav_if.hdng_rdy = 1;
        start_move(0, 0);
        for (int k = 0; k < 6; k++) tick();
        rst_n = 0; tick();
        check("midrst_cmplt", 32'(obs_cmplt), 32'd0);
        rst_n = 1; tick();
        check("midrst_spd", 32'(obs_spd), 32'd0);
        check("midrst_moving", 32'(obs_moving), 32'd0);
        check("midrst_cmplt_after", 32'(obs_cmplt), 32'd0);

        // Simultaneous commands: the turn wins, speed stays at zero.
        nav_if.strt_hdng = 1; nav_if.strt_mv = 1; tick();
        nav_if.strt_hdng = 0; nav_if.strt_mv = 0;
        tick(); tick();
        check("both_moving", 32'(obs_moving), 32'd1);
        check("both_spd", 32'(obs_spd), 32'd0);
        nav_if.at_hdng = 1; tick();
        check("both_turn_done", 32'(obs_cmplt), 32'd1);
        idle_inputs();
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst_n            = ($urandom_range(0, 299) != 0);
            nav_if.strt_hdng = ($urandom_range(0, 19) == 0);
            nav_if.strt_mv   = ($urandom_range(0, 9) == 0);
            nav_if.stp_lft   = $urandom_range(0, 1);
            nav_if.stp_rght  = $urandom_range(0, 1);
            nav_if.hdng_rdy  = ($urandom_range(0, 2) != 0);
            nav_if.at_hdng   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 7) == 0) nav_if.lft_opn  = ~nav_if.lft_opn;
            if ($urandom_range(0, 7) == 0) nav_if.rght_opn = ~nav_if.rght_opn;
            nav_if.frwrd_opn = ($urandom_range(0, 39) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
